multicycle_control: RTL

Multi-cycle control unit that drives the control inputs of the lab CPU datapath (regdst, regwr, branch/jump selection, alucntrl, alusrc, memwr, memtoreg) plus the PC and IR write enables. It decodes the instruction held in the datapath IR and sequences it through fetch, decode, execute, memory and writeback states. It sits beside the datapath and instruction fetch unit, and is the producer of the control interface that the datapath consumes.

---
 rtl/cpu_ctrl_pkg.sv | 50 +++++
 rtl/instr_class_decode.sv | 33 +++
 rtl/multicycle_control.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: opcodes, functs,
// FSM states, instruction classes and datapath select encodings.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
  } state_e;

  typedef enum logic [3:0] {
    C_LW, C_SW, C_J, C_JAL, C_JR, C_BNE, C_ADDI, C_XORI,
    C_RADD, C_RSUB, C_RSLT, C_ILLEGAL
  } iclass_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2, ALU_SLT = 3'd3
  } aluop_e;

  typedef enum logic [1:0] {RDST_RT = 2'd0, RDST_RD = 2'd1, RDST_R31 = 2'd2} regdst_e;
  typedef enum logic [1:0] {MTR_ALU = 2'd0, MTR_MEM = 2'd1, MTR_PC4 = 2'd2} memtoreg_e;
  typedef enum logic [1:0] {PC_PC4 = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_JR = 2'd3} pcsrc_e;

  // ALU controls are a pure function of the class so EXEC/MEM/WB hold them.
  function automatic aluop_e alu_op_of(iclass_e c);
    case (c)
      C_BNE, C_RSUB: return ALU_SUB;
      C_XORI:        return ALU_XOR;
      C_RSLT:        return ALU_SLT;
      default:       return ALU_ADD;
    endcase
  endfunction

  function automatic logic alu_src_of(iclass_e c);
    return c inside {C_LW, C_SW, C_ADDI, C_XORI};
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode/funct to instruction-class mapping.
module instr_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_e    iclass
);

  always_comb begin
    iclass = C_ILLEGAL;
    case (opcode)
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      OP_J:    iclass = C_J;
      OP_JAL:  iclass = C_JAL;
      OP_BNE:  iclass = C_BNE;
      OP_ADDI: iclass = C_ADDI;
      OP_XORI: iclass = C_XORI;
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  iclass = C_RADD;
          FN_SUB:  iclass = C_RSUB;
          FN_SLT:  iclass = C_RSLT;
          FN_JR:   iclass = C_JR;
          default: iclass = C_ILLEGAL;
        endcase
      end
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and decodes datapath control from state and class.
module multicycle_control
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcwr,
  output logic       irwr,
  output logic       regwr,
  output logic       memwr,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrc,
  output logic [2:0] alucntrl,
  output logic [1:0] pcsrc,
  output logic       instrdone,
  output logic       err
);

  state_e  state_q, state_d;
  iclass_e cls_q, cls_d, cls_dec;

  instr_class_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .iclass (cls_dec)
  );

  // The class is captured in DECODE; later opcode/funct changes are ignored.
  always_comb begin
    cls_d = (state_q == S_DECODE) ? cls_dec : cls_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_START;
      cls_q   <= C_ILLEGAL;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pcwr      = 1'b0;
    irwr      = 1'b0;
    regwr     = 1'b0;
    memwr     = 1'b0;
    regdst    = RDST_RT;
    memtoreg  = MTR_ALU;
    alusrc    = 1'b0;
    alucntrl  = ALU_ADD;
    pcsrc     = PC_PC4;
    err       = 1'b0;

    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        irwr    = 1'b1;
        pcwr    = 1'b1;
        pcsrc   = PC_PC4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (cls_dec)
          C_ILLEGAL: state_d = S_ERROR;
          C_J: begin
            pcwr    = 1'b1;
            pcsrc   = PC_JUMP;
            state_d = S_FETCH;
          end
          C_JAL: begin
            pcwr     = 1'b1;
            pcsrc    = PC_JUMP;
            regwr    = 1'b1;
            regdst   = RDST_R31;
            memtoreg = MTR_PC4;
            state_d  = S_FETCH;
          end
          C_JR: begin
            pcwr    = 1'b1;
            pcsrc   = PC_JR;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alucntrl = alu_op_of(cls_q);
        alusrc   = alu_src_of(cls_q);
        case (cls_q)
          C_BNE: begin
            // Branch taken when the SUB result is non-zero (Mealy on zero).
            pcwr    = ~zero;
            pcsrc   = zero ? PC_PC4 : PC_BRANCH;
            state_d = S_FETCH;
          end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        alucntrl = alu_op_of(cls_q);
        alusrc   = alu_src_of(cls_q);
        if (cls_q == C_SW) begin
          memwr   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        alucntrl = alu_op_of(cls_q);
        alusrc   = alu_src_of(cls_q);
        regwr    = 1'b1;
        regdst   = (cls_q inside {C_RADD, C_RSUB, C_RSLT}) ? RDST_RD : RDST_RT;
        memtoreg = (cls_q == C_LW) ? MTR_MEM : MTR_ALU;
        state_d  = S_FETCH;
      end
      S_ERROR: begin
        err     = 1'b1;
        state_d = S_ERROR;
      end
      default: state_d = S_START;
    endcase

    instrdone = (state_d == S_FETCH) && (state_q != S_START);

    // Force quiet outputs while reset is asserted, independent of state timing.
    if (reset) begin
      pcwr      = 1'b0;
      irwr      = 1'b0;
      regwr     = 1'b0;
      memwr     = 1'b0;
      regdst    = RDST_RT;
      memtoreg  = MTR_ALU;
      alusrc    = 1'b0;
      alucntrl  = ALU_ADD;
      pcsrc     = PC_PC4;
      instrdone = 1'b0;
      err       = 1'b0;
    end
  end

endmodule
